// File: rtl/cdu_angle_counter.sv
// ============================================================================
// cdu_angle_counter: CDU error-angle pulse receiver with pending-pulse cells,
// modular angle counter and request/acknowledge snapshot readout.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cdu_angle_counter #(
  parameter int WIDTH       = 15,
  parameter int PEND_W      = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLOCKH,
  input  logic             rst,
  input  logic             UPLVL,
  input  logic             DNLVL,
  input  logic             SLOT,
  input  logic             LD,
  input  logic [WIDTH-1:0] LDDAT,
  input  logic             RDREQ,
  output logic             RDACK,
  output logic [WIDTH-1:0] RDDAT,
  output logic [WIDTH-1:0] ANGLE,
  output logic             OVF,
  output logic             WRAP
);

  localparam logic [PEND_W-1:0] PEND_MAX  = '1;
  localparam logic [WIDTH-1:0]  ANGLE_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACK = 1'b1} rd_state_t;

  logic [SYNC_STAGES-1:0] up_sync_q, dn_sync_q, fill_q;
  logic                   up_prev_q, dn_prev_q, up_arm_q, dn_arm_q;
  logic                   inc_up_q, inc_dn_q;
  logic [PEND_W-1:0]      up_pend_q, up_pend_d, dn_pend_q, dn_pend_d;
  logic [WIDTH-1:0]       angle_q, angle_d, rddat_q, rddat_d;
  logic                   ovf_q, ovf_d, wrap_q, wrap_d;
  logic                   svc, dec_up, dec_dn, drop_up, drop_dn;
  rd_state_t              state_q, state_d;

  // Returns {dropped, next}; a saturated cell holds and drops the new event.
  function automatic logic [PEND_W:0] pend_next(input logic [PEND_W-1:0] cur,
                                                input logic inc, input logic dec);
    if (inc && !dec && cur == PEND_MAX) return {1'b1, cur};
    return {1'b0, cur + {{(PEND_W-1){1'b0}}, inc} - {{(PEND_W-1){1'b0}}, dec}};
  endfunction

  // Edge detection is armed only after a real low is seen once the chain has
  // filled, so a level already high out of reset is not counted.
  always_ff @(posedge CLOCKH) begin
    if (rst) begin
      up_sync_q <= '0;
      dn_sync_q <= '0;
      fill_q    <= '0;
      up_prev_q <= 1'b0;
      dn_prev_q <= 1'b0;
      up_arm_q  <= 1'b0;
      dn_arm_q  <= 1'b0;
      inc_up_q  <= 1'b0;
      inc_dn_q  <= 1'b0;
    end else begin
      up_sync_q <= {up_sync_q[SYNC_STAGES-2:0], UPLVL};
      dn_sync_q <= {dn_sync_q[SYNC_STAGES-2:0], DNLVL};
      fill_q    <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      up_prev_q <= up_sync_q[SYNC_STAGES-1];
      dn_prev_q <= dn_sync_q[SYNC_STAGES-1];
      up_arm_q  <= up_arm_q | (fill_q[SYNC_STAGES-1] & ~up_sync_q[SYNC_STAGES-1]);
      dn_arm_q  <= dn_arm_q | (fill_q[SYNC_STAGES-1] & ~dn_sync_q[SYNC_STAGES-1]);
      inc_up_q  <= up_arm_q & up_sync_q[SYNC_STAGES-1] & ~up_prev_q;
      inc_dn_q  <= dn_arm_q & dn_sync_q[SYNC_STAGES-1] & ~dn_prev_q;
    end
  end

  always_comb begin
    svc       = SLOT & ~LD;
    dec_up    = svc & (up_pend_q != '0);
    dec_dn    = svc & (dn_pend_q != '0);
    {drop_up, up_pend_d} = pend_next(up_pend_q, inc_up_q, dec_up);
    {drop_dn, dn_pend_d} = pend_next(dn_pend_q, inc_dn_q, dec_dn);
    angle_d   = angle_q;
    wrap_d    = 1'b0;
    ovf_d     = ovf_q | drop_up | drop_dn;
    if (LD) begin
      angle_d   = LDDAT;
      up_pend_d = {{(PEND_W-1){1'b0}}, inc_up_q};
      dn_pend_d = {{(PEND_W-1){1'b0}}, inc_dn_q};
      ovf_d     = 1'b0;
    end else if (dec_up && !dec_dn) begin
      angle_d = angle_q + ANGLE_ONE;
      wrap_d  = &angle_q;
    end else if (dec_dn && !dec_up) begin
      angle_d = angle_q - ANGLE_ONE;
      wrap_d  = ~|angle_q;
    end
  end

  always_comb begin
    state_d = state_q;
    rddat_d = rddat_q;
    case (state_q)
      ST_IDLE: if (RDREQ) begin
        rddat_d = angle_q;
        state_d = ST_ACK;
      end
      ST_ACK:  if (!RDREQ) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCKH) begin
    if (rst) begin
      up_pend_q <= '0;
      dn_pend_q <= '0;
      angle_q   <= '0;
      ovf_q     <= 1'b0;
      wrap_q    <= 1'b0;
      rddat_q   <= '0;
      state_q   <= ST_IDLE;
    end else begin
      up_pend_q <= up_pend_d;
      dn_pend_q <= dn_pend_d;
      angle_q   <= angle_d;
      ovf_q     <= ovf_d;
      wrap_q    <= wrap_d;
      rddat_q   <= rddat_d;
      state_q   <= state_d;
    end
  end

  assign ANGLE = angle_q;
  assign OVF   = ovf_q;
  assign WRAP  = wrap_q;
  assign RDDAT = rddat_q;
  assign RDACK = (state_q == ST_ACK);

endmodule

`default_nettype wire

// File: tb/tb_cdu_angle_counter.sv
// ============================================================================
// tb_cdu_angle_counter: table vectors, directed corner sequences and random
// stimulus checked against a sample-history reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cdu_angle_counter;
  localparam int W    = 15;
  localparam int PW   = 3;
  localparam int S    = 2;
  localparam int AMOD = 1 << W;
  localparam int PMAX = (1 << PW) - 1;

  logic         CLOCKH = 1'b0;
  logic         rst = 1'b1, up = 1'b0, dn = 1'b0, slot = 1'b0, ld = 1'b0, rdreq = 1'b0;
  logic [W-1:0] lddat = '0;
  logic         RDACK, OVF, WRAP;
  logic [W-1:0] RDDAT, ANGLE;

  int total = 0;
  int bad   = 0;

  cdu_angle_counter #(.WIDTH(W), .PEND_W(PW), .SYNC_STAGES(S)) dut (
    .CLOCKH(CLOCKH), .rst(rst), .UPLVL(up), .DNLVL(dn), .SLOT(slot), .LD(ld),
    .LDDAT(lddat), .RDREQ(rdreq), .RDACK(RDACK), .RDDAT(RDDAT), .ANGLE(ANGLE),
    .OVF(OVF), .WRAP(WRAP)
  );

  always #5 CLOCKH = ~CLOCKH;

  // Reference model: pulses are recognised from the input sample history
  // (a low sample followed by a high sample) and land S+1 edges later.
  int   m_angle, m_up, m_dn, m_rddat, m_cnt;
  logic m_ovf, m_wrap, m_ack;
  logic uq[$];
  logic dq[$];

  task automatic model_edge();
    logic ev_u, ev_d, su, sd;
    if (rst) begin
      m_angle = 0; m_up = 0; m_dn = 0; m_rddat = 0; m_cnt = 0;
      m_ovf = 0; m_wrap = 0; m_ack = 0;
      uq.delete(); dq.delete();
      return;
    end
    m_cnt++;
    uq.push_back(up);
    dq.push_back(dn);
    if (uq.size() > S + 3) begin
      void'(uq.pop_front());
      void'(dq.pop_front());
    end
    ev_u = (m_cnt >= S + 3) && uq[uq.size()-1-(S+1)] && !uq[uq.size()-1-(S+2)];
    ev_d = (m_cnt >= S + 3) && dq[dq.size()-1-(S+1)] && !dq[dq.size()-1-(S+2)];
    if (!m_ack && rdreq) begin
      m_rddat = m_angle;
      m_ack   = 1;
    end else if (m_ack && !rdreq) begin
      m_ack = 0;
    end
    m_wrap = 0;
    if (ld) begin
      m_angle = int'(lddat);
      m_up = int'(ev_u); m_dn = int'(ev_d);
      m_ovf = 0;
    end else begin
      su = slot && (m_up > 0);
      sd = slot && (m_dn > 0);
      if (su && !sd) begin
        m_wrap  = (m_angle == AMOD - 1);
        m_angle = (m_angle + 1) % AMOD;
      end else if (sd && !su) begin
        m_wrap  = (m_angle == 0);
        m_angle = (m_angle + AMOD - 1) % AMOD;
      end
      m_up = m_up - int'(su) + int'(ev_u);
      m_dn = m_dn - int'(sd) + int'(ev_d);
      if (m_up > PMAX) begin m_up = PMAX; m_ovf = 1; end
      if (m_dn > PMAX) begin m_dn = PMAX; m_ovf = 1; end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLOCKH);
    model_edge();
    #1;
    chk("m_angle", 32'(ANGLE), 32'(m_angle));
    chk("m_wrap",  32'(WRAP),  32'(m_wrap));
    chk("m_ovf",   32'(OVF),   32'(m_ovf));
    chk("m_rdack", 32'(RDACK), 32'(m_ack));
    chk("m_rddat", 32'(RDDAT), 32'(m_rddat));
  endtask

  task automatic pulse(input logic pu, input logic pd);
    repeat (3) begin up = pu; dn = pd; step(); end
    up = 0; dn = 0;
    repeat (3) step();
  endtask

  task automatic slot_step();
    slot = 1; step(); slot = 0;
  endtask

  typedef struct {
    logic         up, dn, slot, ld, rdreq;
    logic [W-1:0] lddat;
    logic [W-1:0] e_angle;
    logic         e_wrap, e_ovf, e_ack;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(input logic u, input logic d, input logic s, input logic l,
                              input logic r, input logic [W-1:0] dat, input logic [W-1:0] ea,
                              input logic ew, input logic eo, input logic ek);
    vec_t v;
    v.up = u; v.dn = d; v.slot = s; v.ld = l; v.rdreq = r; v.lddat = dat;
    v.e_angle = ea; v.e_wrap = ew; v.e_ovf = eo; v.e_ack = ek;
    return v;
  endfunction

  initial begin
    int uh, dh;
    tbl[0]  = mk(0, 0, 0, 1, 0, 15'h7FFF, 15'h7FFF, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 15'h0,    15'h7FFF, 0, 0, 0);
    tbl[2]  = mk(1, 0, 0, 0, 0, 15'h0,    15'h7FFF, 0, 0, 0);
    tbl[3]  = mk(1, 0, 0, 0, 0, 15'h0,    15'h7FFF, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 15'h0,    15'h7FFF, 0, 0, 0);
    tbl[5]  = mk(0, 0, 1, 0, 0, 15'h0,    15'h0000, 1, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 15'h0,    15'h0000, 0, 0, 0);
    tbl[7]  = mk(1, 1, 0, 0, 0, 15'h0,    15'h0000, 0, 0, 0);
    tbl[8]  = mk(1, 1, 0, 0, 0, 15'h0,    15'h0000, 0, 0, 0);
    tbl[9]  = mk(1, 1, 0, 0, 0, 15'h0,    15'h0000, 0, 0, 0);
    tbl[10] = mk(0, 0, 0, 0, 0, 15'h0,    15'h0000, 0, 0, 0);
    tbl[11] = mk(0, 0, 1, 0, 0, 15'h0,    15'h0000, 0, 0, 0);
    tbl[12] = mk(0, 0, 1, 0, 0, 15'h0,    15'h0000, 0, 0, 0);
    tbl[13] = mk(0, 0, 0, 0, 1, 15'h0,    15'h0000, 0, 0, 1);
    tbl[14] = mk(0, 0, 0, 0, 0, 15'h0,    15'h0000, 0, 0, 0);

    // Reset state
    rst = 1; step(); step();
    chk("rst_angle", 32'(ANGLE), 0);
    chk("rst_rdack", 32'(RDACK), 0);
    chk("rst_ovf",   32'(OVF),   0);
    rst = 0;
    repeat (5) step();

    // Single pulse, wrap on up, cancellation, snapshot of zero
    foreach (tbl[i]) begin
      up = tbl[i].up; dn = tbl[i].dn; slot = tbl[i].slot; ld = tbl[i].ld;
      rdreq = tbl[i].rdreq; lddat = tbl[i].lddat;
      step();
      chk("tbl_angle", 32'(ANGLE), 32'(tbl[i].e_angle));
      chk("tbl_wrap",  32'(WRAP),  32'(tbl[i].e_wrap));
      chk("tbl_ovf",   32'(OVF),   32'(tbl[i].e_ovf));
      chk("tbl_rdack", 32'(RDACK), 32'(tbl[i].e_ack));
    end
    up = 0; dn = 0; slot = 0; ld = 0; rdreq = 0;
    step();

    // Saturation: 9 pulses, cell holds 7, OVF sticky
    ld = 1; lddat = '0; step(); ld = 0;
    repeat (9) pulse(1, 0);
    chk("sat_ovf", 32'(OVF), 1);
    repeat (7) slot_step();
    chk("sat_angle7", 32'(ANGLE), 7);
    slot_step();
    chk("sat_angle_hold", 32'(ANGLE), 7);

    // Reset mid-handshake with two pulses pending
    rdreq = 1; step();
    chk("rm_ack", 32'(RDACK), 1);
    pulse(1, 0); pulse(1, 0);
    rst = 1; step();
    chk("rm_angle", 32'(ANGLE), 0);
    chk("rm_rdack", 32'(RDACK), 0);
    chk("rm_rddat", 32'(RDDAT), 0);
    chk("rm_ovf",   32'(OVF),   0);
    chk("rm_wrap",  32'(WRAP),  0);
    rst = 0; rdreq = 0;
    repeat (4) step();
    repeat (3) slot_step();
    chk("rm_after_slot", 32'(ANGLE), 0);
    repeat (2) step();

    // Edge event landing in the same cycle as service
    ld = 1; lddat = 15'h0100; step(); ld = 0;
    pulse(1, 0);
    repeat (3) begin up = 1; step(); end
    up = 0; slot = 1; step(); slot = 0;
    chk("sim_first", 32'(ANGLE), 32'h101);
    slot_step();
    chk("sim_second", 32'(ANGLE), 32'h102);
    slot_step();
    chk("sim_third", 32'(ANGLE), 32'h102);

    // LD with SLOT clears pending
    pulse(1, 0);
    ld = 1; slot = 1; lddat = 15'h0055; step(); ld = 0; slot = 0;
    chk("ldslot_angle", 32'(ANGLE), 32'h55);
    slot_step();
    chk("ldslot_cleared", 32'(ANGLE), 32'h55);

    // Readout snapshot frozen while ANGLE moves
    ld = 1; lddat = 15'h1234; step(); ld = 0;
    rdreq = 1; step();
    chk("rd_ack", 32'(RDACK), 1);
    chk("rd_dat", 32'(RDDAT), 32'h1234);
    repeat (3) begin pulse(0, 1); slot_step(); end
    chk("rd_frozen", 32'(RDDAT), 32'h1234);
    chk("rd_angle",  32'(ANGLE), 32'h1231);
    chk("rd_ack_held", 32'(RDACK), 1);
    rdreq = 0; step();
    chk("rd_drop", 32'(RDACK), 0);

    // Randomized traffic against the model
    uh = 10; dh = 10;
    for (int i = 0; i < 4000; i++) begin
      uh++; dh++;
      if (uh >= S + 1 && $urandom_range(0, 3) == 0) begin up = ~up; uh = 0; end
      if (dh >= S + 1 && $urandom_range(0, 3) == 0) begin dn = ~dn; dh = 0; end
      slot  = ($urandom_range(0, 2) == 0);
      ld    = ($urandom_range(0, 60) == 0);
      lddat = W'($urandom_range(0, AMOD - 1));
      if ($urandom_range(0, 7) == 0) lddat = (lddat[0]) ? '1 : '0;
      if ($urandom_range(0, 4) == 0) rdreq = ~rdreq;
      rst   = ($urandom_range(0, 700) == 0);
      step();
    end
    rst = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
